// File: rtl/result_checker_param.sv
// Snoops data-memory stores to TEST_PORT and scores them against a loadable answer table; outputs registered, pure snooper (never stalls the bus).
// Define CHECKER_ENDIAN_SWAP_EN to byte-reverse bus data into readable order before comparison.
module result_checker_param #(
  parameter int                ADDR_W       = 30,
  parameter int                DATA_W       = 32,
  parameter logic [ADDR_W-1:0] TEST_PORT    = 30'h10,
  parameter logic [DATA_W-1:0] BEGIN_SYMBOL = 32'h00000168,
  parameter logic [DATA_W-1:0] END_SYMBOL   = 32'hFFFFFD5D,
  parameter int                CHECK_NUM    = 19,
  parameter int                IDX_W        = 5,
  parameter int                ERR_W        = 8,
  parameter int                DUR_W        = 16,
  parameter logic [DUR_W-1:0]  MAX_CYCLES   = 16'hFFF0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              wen,
  input  logic              hit_count,
  input  logic              ans_we,
  input  logic [IDX_W-1:0]  ans_idx,
  input  logic [DATA_W-1:0] ans_data,
  output logic [ERR_W-1:0]  error_num,
  output logic [DUR_W-1:0]  duration,
  output logic              finish,
  output logic              timeout,
  output logic [IDX_W-1:0]  first_err_idx,
  output logic [DATA_W-1:0] first_err_data,
  output logic [31:0]       total_cycles,
  output logic [31:0]       hit_cycles
);

  typedef enum logic [1:0] {IDLE, CHECK, REPORT} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHECK_NUM - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = {{(ERR_W-1){1'b1}}, 1'b0};

  state_t            state_q, state_d;
  logic              trk_q, trk_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [DUR_W-1:0]  dur_q, dur_d;
  logic              fin_q, fin_d;
  logic              to_q, to_d;
  logic [IDX_W-1:0]  fidx_q, fidx_d;
  logic [DATA_W-1:0] fdat_q, fdat_d;
  logic [31:0]       tot_q, tot_d;
  logic [31:0]       hit_q, hit_d;

  logic [DATA_W-1:0] ans_tab [0:(1<<IDX_W)-1];
  logic [DATA_W-1:0] cmp_val;
  logic [DATA_W-1:0] exp_val;
  logic              test_st;

  always_comb begin
    cmp_val = data;
`ifdef CHECKER_ENDIAN_SWAP_EN
    for (int b = 0; b < DATA_W/8; b++) begin
      cmp_val[8*b +: 8] = data[DATA_W-8*(b+1) +: 8];
    end
`endif
  end

  // One store per wen rising edge, so a store held across cache stalls counts once.
  assign test_st = wen && !trk_q && (addr == TEST_PORT);
  assign exp_val = (idx_q == LAST_IDX) ? END_SYMBOL : ans_tab[idx_q];

  always_comb begin
    state_d = state_q;
    trk_d   = wen;
    idx_d   = idx_q;
    err_d   = err_q;
    dur_d   = dur_q;
    fin_d   = fin_q;
    to_d    = to_q;
    fidx_d  = fidx_q;
    fdat_d  = fdat_q;
    tot_d   = tot_q + 32'd1;
    hit_d   = hit_q + 32'(hit_count);
    case (state_q)
      IDLE: begin
        dur_d = '0;
        if (test_st && cmp_val == BEGIN_SYMBOL) begin
          state_d = CHECK;
          err_d   = '0;
          idx_d   = '0;
        end
      end
      CHECK: begin
        if (dur_q != '1) dur_d = dur_q + 1'b1;
        if (test_st) begin
          if (cmp_val != exp_val) begin
            if (err_q == '0) begin
              fidx_d = idx_q;
              fdat_d = cmp_val;
            end
            if (err_q != ERR_MAX) err_d = err_q + 1'b1;
          end
          idx_d = idx_q + 1'b1;
        end
        // A completing store beats a coincident timeout.
        if (test_st && idx_q == LAST_IDX) begin
          state_d = REPORT;
          fin_d   = 1'b1;
        end else if (dur_q == MAX_CYCLES) begin
          state_d = REPORT;
          fin_d   = 1'b1;
          to_d    = 1'b1;
          dur_d   = dur_q;
        end
      end
      REPORT: ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      trk_q   <= 1'b0;
      idx_q   <= '0;
      err_q   <= '1;
      dur_q   <= '0;
      fin_q   <= 1'b0;
      to_q    <= 1'b0;
      fidx_q  <= '0;
      fdat_q  <= '0;
      tot_q   <= '0;
      hit_q   <= '0;
    end else begin
      state_q <= state_d;
      trk_q   <= trk_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      dur_q   <= dur_d;
      fin_q   <= fin_d;
      to_q    <= to_d;
      fidx_q  <= fidx_d;
      fdat_q  <= fdat_d;
      tot_q   <= tot_d;
      hit_q   <= hit_d;
    end
  end

  // Answer table survives reset so a rerun needs no reload.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && ans_we && ans_idx < LAST_IDX) ans_tab[ans_idx] <= ans_data;
  end

  assign error_num      = err_q;
  assign duration       = dur_q;
  assign finish         = fin_q;
  assign timeout        = to_q;
  assign first_err_idx  = fidx_q;
  assign first_err_data = fdat_q;
  assign total_cycles   = tot_q;
  assign hit_cycles     = hit_q;

endmodule

// File: tb/tb_result_checker_param.sv
// Directed bench for result_checker_param: scenario table for full runs plus reset, timeout and hit-counter sequences.
module tb_result_checker_param;

  localparam logic [29:0] PORT  = 30'h10;
  localparam logic [29:0] OTHER = 30'h11;
  localparam logic [31:0] BEGV  = 32'h00000168;
  localparam logic [31:0] ENDV  = 32'hFFFFFD5D;
  localparam logic [31:0] WRONG = 32'h12345678;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, wen, hit_count, ans_we;
  logic [29:0] addr;
  logic [31:0] data, ans_data;
  logic [4:0]  ans_idx;

  logic [7:0]  err_a, err_b;
  logic [15:0] dur_a, dur_b;
  logic        fin_a, fin_b, to_a, to_b;
  logic [4:0]  fidx_a, fidx_b;
  logic [31:0] fdat_a, fdat_b, tot_a, tot_b, hit_a, hit_b;

  result_checker_param dut (
    .clk(clk), .rst(rst), .addr(addr), .data(data), .wen(wen), .hit_count(hit_count),
    .ans_we(ans_we), .ans_idx(ans_idx), .ans_data(ans_data),
    .error_num(err_a), .duration(dur_a), .finish(fin_a), .timeout(to_a),
    .first_err_idx(fidx_a), .first_err_data(fdat_a), .total_cycles(tot_a), .hit_cycles(hit_a)
  );

  result_checker_param #(.MAX_CYCLES(16'd100)) dut_to (
    .clk(clk), .rst(rst), .addr(addr), .data(data), .wen(wen), .hit_count(hit_count),
    .ans_we(ans_we), .ans_idx(ans_idx), .ans_data(ans_data),
    .error_num(err_b), .duration(dur_b), .finish(fin_b), .timeout(to_b),
    .first_err_idx(fidx_b), .first_err_data(fdat_b), .total_cycles(tot_b), .hit_cycles(hit_b)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          bad0;
    int          bad1;
    int          hold;
    bit          ilv;
    logic [7:0]  e_err;
    logic [4:0]  e_fidx;
    logic [31:0] e_fdat;
    logic [15:0] e_dur;
  } vec_t;

  logic [31:0] answers [18];
  vec_t        vecs [4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] to_bus(input logic [31:0] v);
`ifdef CHECKER_ENDIAN_SWAP_EN
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
`else
    return v;
`endif
  endfunction

  function automatic logic [31:0] word(input int k);
    return (k == 18) ? ENDV : answers[k];
  endfunction

  // Called at a negedge; wen high for 'hold' edges, then low for one edge.
  task automatic store(input logic [29:0] a, input logic [31:0] v, input int hold);
    addr = a;
    data = to_bus(v);
    wen  = 1'b1;
    repeat (hold) @(negedge clk);
    wen = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_stores(input int hold, input bit ilv, input int bad0, input int bad1, input int n);
    store(PORT, BEGV, hold);
    for (int k = 0; k < n; k++) begin
      if (ilv) store(OTHER, 32'hCAFE0000 | k, 1);
      store(PORT, (k == bad0 || k == bad1) ? WRONG : word(k), hold);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b1; wen = 1'b0; hit_count = 1'b0; ans_we = 1'b0;
    addr = '0; data = '0; ans_idx = '0; ans_data = '0;

    answers = '{32'h00001234, 32'h0000ABCD, 32'h091A0000, 32'h00000005, 32'h0000002A,
                32'hDEADBEEF, 32'h00C0FFEE, 32'h12340000, 32'h7FFFFFFF, 32'h80000000,
                32'h0000FFFF, 32'hFFFF0000, 32'h01020304, 32'hA5A5A5A5, 32'h5A5A5A5A,
                32'h00000001, 32'hFFFFFFFE, 32'h0C374FA4};
    vecs[0] = '{bad0: -1, bad1: -1, hold: 1, ilv: 1'b0, e_err: 8'd0, e_fidx: 5'd0,  e_fdat: 32'h0,  e_dur: 16'd38};
    vecs[1] = '{bad0: 2,  bad1: 6,  hold: 1, ilv: 1'b0, e_err: 8'd2, e_fidx: 5'd2,  e_fdat: WRONG,  e_dur: 16'd38};
    vecs[2] = '{bad0: -1, bad1: -1, hold: 5, ilv: 1'b1, e_err: 8'd0, e_fidx: 5'd0,  e_fdat: 32'h0,  e_dur: 16'd152};
    vecs[3] = '{bad0: 18, bad1: -1, hold: 1, ilv: 1'b0, e_err: 8'd1, e_fidx: 5'd18, e_fdat: WRONG,  e_dur: 16'd38};

    #2 rst = 1'b0;
    #1;
    chk("rst_error_num", err_a, 8'hFF);
    chk("rst_duration", dur_a, 16'd0);
    chk("rst_finish", fin_a, 1'b0);
    chk("rst_timeout", to_a, 1'b0);
    chk("rst_first_idx", fidx_a, 5'd0);
    chk("rst_first_data", fdat_a, 32'd0);
    chk("rst_total", tot_a, 32'd0);
    chk("rst_hit", hit_a, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 19; i++) begin
      ans_we   = 1'b1;
      ans_idx  = 5'(i);
      ans_data = (i < 18) ? answers[i] : 32'hDEAD0000;
      @(negedge clk);
    end
    ans_we = 1'b0;

    for (int v = 0; v < 4; v++) begin
      do_reset();
      run_stores(vecs[v].hold, vecs[v].ilv, vecs[v].bad0, vecs[v].bad1, 18);
      chk($sformatf("v%0d_finish_before_last", v), fin_a, 1'b0);
      if (vecs[v].ilv) store(OTHER, 32'hCAFE00FF, 1);
      store(PORT, (vecs[v].bad0 == 18) ? WRONG : ENDV, vecs[v].hold);
      chk($sformatf("v%0d_finish", v), fin_a, 1'b1);
      chk($sformatf("v%0d_timeout", v), to_a, 1'b0);
      chk($sformatf("v%0d_error_num", v), err_a, vecs[v].e_err);
      chk($sformatf("v%0d_first_idx", v), fidx_a, vecs[v].e_fidx);
      chk($sformatf("v%0d_first_data", v), fdat_a, vecs[v].e_fdat);
      chk($sformatf("v%0d_duration", v), dur_a, vecs[v].e_dur);
      store(PORT, WRONG, 1);
      chk($sformatf("v%0d_report_hold", v), err_a, vecs[v].e_err);
    end

    // Reset in the middle of CHECK, then rerun without reloading the table.
    do_reset();
    store(PORT, 32'h0BADF00D, 1);
    chk("idle_ignore_err", err_a, 8'hFF);
    chk("idle_duration", dur_a, 16'd0);
    run_stores(1, 1'b0, -1, -1, 10);
    chk("mid_check_err", err_a, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_error_num", err_a, 8'hFF);
    chk("midrst_duration", dur_a, 16'd0);
    chk("midrst_finish", fin_a, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    chk("pre_begin_err", err_a, 8'hFF);
    run_stores(1, 1'b0, -1, -1, 19);
    chk("rerun_finish", fin_a, 1'b1);
    chk("rerun_error_num", err_a, 8'd0);

    // Timeout on the MAX_CYCLES=100 instance after only four stores.
    do_reset();
    run_stores(1, 1'b0, 1, -1, 4);
    begin
      int n = 0;
      while (!fin_b && n < 300) begin
        @(negedge clk);
        n++;
      end
    end
    chk("to_finish", fin_b, 1'b1);
    chk("to_timeout", to_b, 1'b1);
    chk("to_duration", dur_b, 16'd100);
    chk("to_error_num", err_b, 8'd1);
    chk("to_main_finish", fin_a, 1'b0);
    chk("to_main_timeout", to_a, 1'b0);

    do_reset();
    for (int i = 0; i < 200; i++) begin
      hit_count = (i < 74) && (i % 2 == 0);
      @(negedge clk);
    end
    hit_count = 1'b0;
    chk("hit_cycles", hit_a, 32'd37);
    chk("total_cycles", tot_a, 32'd200);
    chk("hit_cycles_to", hit_b, 32'd37);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
